bytes_to_bridge: RTL and testbench

- Read-direction counterpart of the bridge byte writer. Serves 32-bit bridge read requests by issuing four sequential byte reads to a byte-wide core memory port, then returning the assembled word.
- Sits in the core clock domain, behind the bridge CDC. Gives the host read-back of ROM/RAM regions that the byte writer loads.

---
 rtl/bytes_to_bridge.sv | 129 ++++++++++++
 tb/tb_bytes_to_bridge.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/bytes_to_bridge.sv
// Bridge read server: turns one 32-bit read into four sequential byte reads and
// returns the big-endian word. Optional `BYTES_TO_BRIDGE_OVERRUN_EN adds a sticky overrun flag.
module bytes_to_bridge #(
  parameter int ADDR_WIDTH  = 25,
  parameter int CYCLES      = 8,
  parameter int MEM_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rd,
  input  logic [31:0]           addr,
  output logic [31:0]           rd_data,
  output logic                  rd_valid,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rd,
`ifdef BYTES_TO_BRIDGE_OVERRUN_EN
  output logic                  overrun,
`endif
  input  logic [7:0]            mem_rd_data
);

  generate
    if (MEM_LATENCY < 1 || MEM_LATENCY >= CYCLES) begin : g_bad_latency
      $error("bytes_to_bridge: MEM_LATENCY must satisfy 1 <= MEM_LATENCY < CYCLES");
    end
  endgenerate

  localparam int CNT_W = $clog2(CYCLES);

  typedef enum logic [1:0] {IDLE, ISSUE, SLOT, DONE} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [1:0]         k;
  logic [31:0]        asm_word, asm_nxt;
  logic               capture, slot_end;
  logic               unused_addr_bits;

  assign unused_addr_bits = ^{addr[31:ADDR_WIDTH], addr[1:0]};

  // Offset 0 lands in the top byte lane (big-endian assembly).
  function automatic logic [31:0] put_byte(input logic [31:0] word,
                                           input logic [1:0]  lane,
                                           input logic [7:0]  b);
    logic [31:0] w;
    w = word;
    w[{~lane, 3'b000} +: 8] = b;
    return w;
  endfunction

  // ISSUE is slot cycle 0, so cnt counts clocks since the mem_rd pulse.
  assign capture  = (state == SLOT) && (cnt == CNT_W'(MEM_LATENCY));
  assign slot_end = (state == SLOT) && (cnt == CNT_W'(CYCLES - 1));
  assign asm_nxt  = capture ? put_byte(asm_word, k, mem_rd_data) : asm_word;

  always_comb begin
    state_nxt = state;
    mem_rd    = 1'b0;
    rd_valid  = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (rd) state_nxt = ISSUE;
      end
      ISSUE: begin
        mem_rd    = 1'b1;
        state_nxt = SLOT;
      end
      SLOT: begin
        if (slot_end) state_nxt = (k == 2'd3) ? DONE : ISSUE;
      end
      DONE: begin
        rd_valid  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Control and visible outputs: reset abandons any request in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      k        <= 2'd0;
      rd_data  <= 32'd0;
      mem_addr <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (rd) begin
            cnt      <= '0;
            k        <= 2'd0;
            mem_addr <= {addr[ADDR_WIDTH-1:2], 2'b00};
          end
        end
        ISSUE: cnt <= CNT_W'(1);
        SLOT: begin
          if (slot_end) begin
            cnt           <= '0;
            k             <= k + 2'd1;
            mem_addr[1:0] <= k + 2'd1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
      // Loaded on entry to DONE so rd_data is valid alongside rd_valid.
      if (slot_end && k == 2'd3) rd_data <= asm_nxt;
    end
  end

  // Assembly register is pure data and needs no reset.
  always_ff @(posedge clk) begin
    asm_word <= asm_nxt;
  end

`ifdef BYTES_TO_BRIDGE_OVERRUN_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          overrun <= 1'b0;
    else if (rd && busy) overrun <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_bytes_to_bridge.sv
// Self-checking bench for bytes_to_bridge: default instance plus a CYCLES=4,
// MEM_LATENCY=3 instance, each with a latency-exact byte memory model.
module tb_bytes_to_bridge;

  localparam int CYC_A = 8;
  localparam int LAT_A = 2;
  localparam int CYC_B = 4;
  localparam int LAT_B = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        rd_a, rd_b;
  logic [31:0] addr_a, addr_b;
  logic [31:0] rd_data_a, rd_data_b;
  logic        rd_valid_a, rd_valid_b, busy_a, busy_b, mem_rd_a, mem_rd_b;
  logic [24:0] mem_addr_a, mem_addr_b;
  logic [7:0]  mem_rd_data_a, mem_rd_data_b;
`ifdef BYTES_TO_BRIDGE_OVERRUN_EN
  logic        overrun_a, overrun_b;
`endif

  bytes_to_bridge #(.ADDR_WIDTH(25), .CYCLES(CYC_A), .MEM_LATENCY(LAT_A)) dut_a (
    .clk(clk), .reset(reset), .rd(rd_a), .addr(addr_a), .rd_data(rd_data_a),
    .rd_valid(rd_valid_a), .busy(busy_a), .mem_addr(mem_addr_a), .mem_rd(mem_rd_a),
`ifdef BYTES_TO_BRIDGE_OVERRUN_EN
    .overrun(overrun_a),
`endif
    .mem_rd_data(mem_rd_data_a));

  bytes_to_bridge #(.ADDR_WIDTH(25), .CYCLES(CYC_B), .MEM_LATENCY(LAT_B)) dut_b (
    .clk(clk), .reset(reset), .rd(rd_b), .addr(addr_b), .rd_data(rd_data_b),
    .rd_valid(rd_valid_b), .busy(busy_b), .mem_addr(mem_addr_b), .mem_rd(mem_rd_b),
`ifdef BYTES_TO_BRIDGE_OVERRUN_EN
    .overrun(overrun_b),
`endif
    .mem_rd_data(mem_rd_data_b));

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h, expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory models: data is valid only in the cycle exactly LAT clocks after mem_rd.
  logic [7:0]  mem_a [0:1023];
  logic [7:0]  mem_b [0:1023];
  int          dca = 100, dcb = 100;
  logic [24:0] pa, pb;

  always @(negedge clk) begin
    if (mem_rd_a) begin dca = 0; pa = mem_addr_a; end
    else dca = dca + 1;
    mem_rd_data_a = (dca == LAT_A) ? mem_a[pa[9:0]] : 8'hA5;
    if (mem_rd_b) begin dcb = 0; pb = mem_addr_b; end
    else dcb = dcb + 1;
    mem_rd_data_b = (dcb == LAT_B) ? mem_b[pb[9:0]] : 8'hA5;
  end

  // Scoreboard: words are queued on acceptance and popped on rd_valid.
  always @(posedge clk) begin
    #1;
    if (rd_valid_a === 1'b1) begin
      if (exp_q.size() == 0) chk("unexpected_rd_valid", {31'd0, rd_valid_a}, 32'd0);
      else chk("sb_rd_data", rd_data_a, exp_q.pop_front());
    end
  end

  typedef struct {
    logic [31:0] addr;
    logic [24:0] base;
    logic [31:0] word;
  } vec_t;
  vec_t vecs[5];

  task automatic run_req_a(input logic [31:0] a, input logic [24:0] base, input logic [31:0] word);
    @(negedge clk);
    rd_a   = 1'b1;
    addr_a = a;
    @(posedge clk);
    exp_q.push_back(word);
    for (int off = 0; off <= 34; off++) begin
      if (off > 0) @(posedge clk);
      #1;
      if (off == 0) rd_a = 1'b0;
      chk("mem_rd", {31'd0, mem_rd_a}, {31'd0, (off % CYC_A == 0) && (off < 4 * CYC_A)});
      if ((off % CYC_A == 0) && (off < 4 * CYC_A))
        chk("mem_addr", {7'd0, mem_addr_a}, {7'd0, base} + 32'(off / CYC_A));
      chk("rd_valid_time", {31'd0, rd_valid_a}, {31'd0, off == 4 * CYC_A});
      chk("busy", {31'd0, busy_a}, {31'd0, off <= 4 * CYC_A});
    end
  endtask

  int npulse;

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem_a[i] = 8'(i + 17);
      mem_b[i] = 8'h77;
    end
    mem_a[10'h100] = 8'hDE; mem_a[10'h101] = 8'hAD;
    mem_a[10'h102] = 8'hBE; mem_a[10'h103] = 8'hEF;
    mem_b[10'h040] = 8'h01; mem_b[10'h041] = 8'h02;
    mem_b[10'h042] = 8'h03; mem_b[10'h043] = 8'h04;

    vecs[0] = '{32'h0000_0100, 25'h000_0100, 32'hDEAD_BEEF};
    vecs[1] = '{32'h0000_0102, 25'h000_0100, 32'hDEAD_BEEF};
    vecs[2] = '{32'hFE00_0204, 25'h000_0204, 32'h1516_1718};
    vecs[3] = '{32'h01FF_FFFF, 25'h1FF_FFFC, 32'h0D0E_0F10};
    vecs[4] = '{32'h0000_03F8, 25'h000_03F8, 32'h090A_0B0C};

    reset = 1'b1; rd_a = 1'b0; rd_b = 1'b0; addr_a = 32'd0; addr_b = 32'd0;
    #1;
    chk("rst_rd_data", rd_data_a, 32'd0);
    chk("rst_rd_valid", {31'd0, rd_valid_a}, 32'd0);
    chk("rst_busy", {31'd0, busy_a}, 32'd0);
    chk("rst_mem_rd", {31'd0, mem_rd_a}, 32'd0);
    chk("rst_mem_addr", {7'd0, mem_addr_a}, 32'd0);
    chk("rst_b_busy", {31'd0, busy_b}, 32'd0);
`ifdef BYTES_TO_BRIDGE_OVERRUN_EN
    chk("rst_overrun", {31'd0, overrun_a}, 32'd0);
`endif
    repeat (3) @(negedge clk);
    reset = 1'b0;

    for (int v = 0; v < 5; v++) run_req_a(vecs[v].addr, vecs[v].base, vecs[v].word);

    // rd held for 40 cycles: accepted at 0 and 34, completions at 32 and 66.
    npulse = 0;
    @(negedge clk);
    rd_a = 1'b1; addr_a = 32'h0000_0100;
    for (int c = 0; c < 80; c++) begin
      @(posedge clk);
      #1;
      if (c == 0 || c == 34) exp_q.push_back(32'hDEAD_BEEF);
      if (c == 39) rd_a = 1'b0;
      if (rd_valid_a) npulse++;
      chk("held_rd_valid", {31'd0, rd_valid_a}, {31'd0, c == 32 || c == 66});
      chk("held_busy", {31'd0, busy_a}, {31'd0, !(c == 33 || c >= 67)});
`ifdef BYTES_TO_BRIDGE_OVERRUN_EN
      chk("overrun", {31'd0, overrun_a}, {31'd0, c >= 1});
`endif
    end
    chk("held_pulse_count", npulse, 32'd2);

    // Reset 12 cycles into a request abandons it.
    @(negedge clk);
    rd_a = 1'b1; addr_a = 32'h0000_0204;
    @(posedge clk);
    #1 rd_a = 1'b0;
    repeat (12) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_rd_data", rd_data_a, 32'd0);
    chk("mid_rst_busy", {31'd0, busy_a}, 32'd0);
    chk("mid_rst_mem_addr", {7'd0, mem_addr_a}, 32'd0);
    chk("mid_rst_rd_valid", {31'd0, rd_valid_a}, 32'd0);
`ifdef BYTES_TO_BRIDGE_OVERRUN_EN
    chk("mid_rst_overrun", {31'd0, overrun_a}, 32'd0);
`endif
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1 chk("abandoned_rd_valid", {31'd0, rd_valid_a}, 32'd0);
    end
    run_req_a(vecs[2].addr, vecs[2].base, vecs[2].word);
    chk("sb_drained", exp_q.size(), 32'd0);

    // Short slots with latency CYCLES-1: last byte arrives on the slot's final cycle.
    @(negedge clk);
    rd_b = 1'b1; addr_b = 32'h0000_0040;
    @(posedge clk);
    for (int off = 0; off <= 18; off++) begin
      if (off > 0) @(posedge clk);
      #1;
      if (off == 0) rd_b = 1'b0;
      chk("b_mem_rd", {31'd0, mem_rd_b}, {31'd0, (off % CYC_B == 0) && (off < 4 * CYC_B)});
      chk("b_rd_valid", {31'd0, rd_valid_b}, {31'd0, off == 4 * CYC_B});
      if (off == 4 * CYC_B) chk("b_rd_data", rd_data_b, 32'h0102_0304);
    end
    chk("b_rd_data_hold", rd_data_b, 32'h0102_0304);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
